// File: rtl/keyscan_pkg.sv
// Shared types and helpers for the keyscan debounce scheduler:
// scheduler state enum, event record and width helpers.
package keyscan_pkg;

  // Widest event code ever needed (up to 64 inputs).
  localparam int KS_CODE_W = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TIME   = 2'd1,
    COMMIT = 2'd2
  } ks_state_e;

  typedef struct packed {
    logic [KS_CODE_W-1:0] code;
    logic                 press;
  } ks_evt_t;

  // Number of bits needed to represent v (at least 1).
  function automatic int GET_WIDTH(input int v);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((v >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

  // Ceiling log2, with a floor of 1 so a 2-entry space still gets a bit.
  function automatic int clog2(input int v);
    return (v <= 2) ? 1 : GET_WIDTH(v - 1);
  endfunction

endpackage

// File: rtl/keyscan_evt_fifo.sv
// Small synchronous FIFO for press/release events. Head is shown
// combinationally from storage; empty FIFO presents all-zero data.
module keyscan_evt_fifo
  import keyscan_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = o_empty ? '0 : r_mem[r_rd];

  // Event storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/keyscan_ctrl.sv
// Debounce scheduler: one shared timer is locked onto one unstable input
// at a time (round-robin scan), and the clean level is committed once the
// input has held for CLK_COUNT cycles. Changes are queued as events.
// Optional macro KEYSCAN_SYNC_EN adds a 2-flop synchroniser on sig_i.
module keyscan_ctrl
  import keyscan_pkg::*;
#(
  parameter int   N          = 16,
  parameter int   CLK_FREQ   = 100,
  parameter int   JITTER_MAX = 10000,
  parameter logic INIT_VALUE = 1'b0,
  parameter int   DEPTH      = 4,
  localparam int  IDX_W      = clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     sig_i,
  output logic [N-1:0]     sig_o,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W-1:0] evt_code,
  output logic             evt_press,
  output logic             busy,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam int CLK_COUNT = CLK_FREQ * JITTER_MAX;
  localparam int CNT_W     = GET_WIDTH(CLK_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_COUNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  ks_state_e        r_state;
  ks_state_e        w_nxt_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_cur;
  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0]     r_sig;
  logic             r_ovf;
  logic [N-1:0]     w_raw;
  logic             w_lock;
  logic             w_scan;
  logic             w_abort;
  logic             w_cnt_inc;
  logic             w_commit;
  logic             w_busy;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [IDX_W:0]   w_fifo_din;
  logic [IDX_W:0]   w_fifo_dout;
  ks_evt_t          w_head;
  logic             w_unused_head;

  function automatic logic [IDX_W-1:0] f_next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_LAST) ? '0 : i + IDX_W'(1);
  endfunction

`ifdef KEYSCAN_SYNC_EN
  logic [N-1:0] r_sync1;
  logic [N-1:0] r_sync2;

  // Two-flop synchroniser bringing the raw pins into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= {N{INIT_VALUE}};
      r_sync2 <= {N{INIT_VALUE}};
    end else begin
      r_sync1 <= sig_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_raw = r_sync2;
`else
  assign w_raw = sig_i;
`endif

  // Scheduler state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt_state;
  end

  // Next-state decode and per-state action strobes.
  always_comb begin
    w_nxt_state = r_state;
    w_lock      = 1'b0;
    w_scan      = 1'b0;
    w_abort     = 1'b0;
    w_cnt_inc   = 1'b0;
    w_commit    = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_raw[r_ptr] != r_sig[r_ptr]) begin
          w_lock      = 1'b1;
          w_nxt_state = TIME;
        end else begin
          w_scan = 1'b1;
        end
      end
      TIME: begin
        w_busy = 1'b1;
        if (w_raw[r_cur] == r_sig[r_cur]) begin
          w_abort     = 1'b1;
          w_nxt_state = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_nxt_state = COMMIT;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      COMMIT: begin
        w_busy      = 1'b1;
        w_commit    = 1'b1;
        w_nxt_state = IDLE;
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  // Scan pointer, locked index and jitter-window counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_cur <= '0;
      r_cnt <= '0;
    end else begin
      if (w_lock) begin
        r_cur <= r_ptr;
        r_cnt <= '0;
      end
      if (w_scan)              r_ptr <= f_next_idx(r_ptr);
      if (w_abort || w_commit) r_ptr <= f_next_idx(r_cur);
      if (w_cnt_inc)           r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Clean levels and sticky overflow; a set beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= {N{INIT_VALUE}};
      r_ovf <= 1'b0;
    end else begin
      if (w_commit) r_sig[r_cur] <= ~r_sig[r_cur];
      if (w_commit && w_full) r_ovf <= 1'b1;
      else if (ovf_clr)       r_ovf <= 1'b0;
    end
  end

  // Fullness is taken before any same-cycle pop, so a full FIFO drops.
  assign w_push     = w_commit && !w_full;
  assign w_pop      = !w_empty && evt_ready;
  assign w_fifo_din = {r_cur, ~r_sig[r_cur]};

  keyscan_evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (IDX_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_fifo_din),
    .i_pop   (w_pop),
    .o_data  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head.code   = KS_CODE_W'(w_fifo_dout[IDX_W:1]);
  assign w_head.press  = w_fifo_dout[0];
  assign w_unused_head = ^w_head.code;

  assign sig_o     = r_sig;
  assign evt_valid = !w_empty;
  assign evt_code  = w_head.code[IDX_W-1:0];
  assign evt_press = w_head.press;
  assign busy      = w_busy;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_keyscan_ctrl.sv
// Bench for keyscan_ctrl (N=4, CLK_COUNT=4, DEPTH=2): directed scenarios
// plus randomized toggling, all checked every cycle against a
// lock-age based reference model with an event queue.
module tb_keyscan_ctrl;

  localparam int N         = 4;
  localparam int CLK_COUNT = 4;
  localparam int DEPTH     = 2;

  typedef struct {
    int code;
    bit press;
  } ev_t;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] sig_i;
  logic [N-1:0] sig_o;
  logic         evt_valid;
  logic         evt_ready;
  logic [1:0]   evt_code;
  logic         evt_press;
  logic         busy;
  logic         ovf;
  logic         ovf_clr;

  int n_tests;
  int n_fail;
  int cyc;

  // reference model state
  int           m_ptr;
  int           m_lock;
  int           m_age;
  logic [N-1:0] m_clean;
  bit           m_ovf;
  ev_t          m_q[$];

  keyscan_ctrl #(
    .N          (N),
    .CLK_FREQ   (1),
    .JITTER_MAX (4),
    .INIT_VALUE (1'b0),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_i     (sig_i),
    .sig_o     (sig_o),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_press (evt_press),
    .busy      (busy),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void m_reset();
    m_ptr   = 0;
    m_lock  = -1;
    m_age   = 0;
    m_clean = '0;
    m_ovf   = 0;
    m_q.delete();
  endfunction

  // One clock of the rules: an input locked for age cycles is in its
  // jitter window for ages 1..CLK_COUNT and commits at age CLK_COUNT+1.
  function automatic void m_step();
    bit  do_pop;
    bit  was_full;
    bit  overflow;
    bit  do_push;
    ev_t ev;
    do_pop   = (m_q.size() > 0) && evt_ready;
    was_full = (m_q.size() >= DEPTH);
    overflow = 0;
    do_push  = 0;
    if (m_lock < 0) begin
      if (sig_i[m_ptr] != m_clean[m_ptr]) begin
        m_lock = m_ptr;
        m_age  = 0;
      end else begin
        m_ptr = (m_ptr + 1) % N;
      end
    end else begin
      m_age++;
      if (m_age <= CLK_COUNT) begin
        if (sig_i[m_lock] == m_clean[m_lock]) begin
          m_ptr  = (m_lock + 1) % N;
          m_lock = -1;
        end
      end else begin
        m_clean[m_lock] = ~m_clean[m_lock];
        if (was_full) overflow = 1;
        else begin
          do_push  = 1;
          ev.code  = m_lock;
          ev.press = m_clean[m_lock];
        end
        m_ptr  = (m_lock + 1) % N;
        m_lock = -1;
      end
    end
    if (do_pop) void'(m_q.pop_front());
    if (do_push) m_q.push_back(ev);
    if (overflow) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
  endfunction

  task automatic compare();
    int e_code;
    bit e_press;
    e_code  = 0;
    e_press = 0;
    if (m_q.size() > 0) begin
      e_code  = m_q[0].code;
      e_press = m_q[0].press;
    end
    chk("sig_o", sig_o, m_clean);
    chk("evt_valid", evt_valid, m_q.size() > 0);
    chk("evt_code", evt_code, e_code);
    chk("evt_press", evt_press, e_press);
    chk("busy", busy, m_lock >= 0);
    chk("ovf", ovf, m_ovf);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) m_reset();
    else        m_step();
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    m_reset();
    compare();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int t_lock;
    int t_rise;
    int got_codes[$];
    int bitn;

    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    sig_i     = 4'hF;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;
    m_reset();

    // reset held with all inputs high
    repeat (3) @(negedge clk);
    chk("rst_sig_o", sig_o, 4'h0);
    chk("rst_evt_valid", evt_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_evt_code", evt_code, 2'd0);
    rst_n = 1'b1;
    step();
    chk("first_lock", busy, 1'b1);
    repeat (40) step();
    chk("all_high", sig_o, 4'hF);
    sig_i = 4'h0;
    repeat (40) step();
    chk("all_low", sig_o, 4'h0);

    // clean press on input 2
    t_lock = -1;
    t_rise = -1;
    sig_i  = 4'b0100;
    for (int i = 0; i < 30; i++) begin
      step();
      if (busy && t_lock < 0) t_lock = cyc - 1;
      if (sig_o[2] && t_rise < 0) begin
        t_rise = cyc;
        chk("press_evt_valid", evt_valid, 1'b1);
        chk("press_evt_code", evt_code, 2'd2);
        chk("press_evt_press", evt_press, 1'b1);
      end
    end
    chk("press_latency", t_rise - t_lock, 6);

    // glitch on input 1
    sig_i = 4'b0110;
    repeat (3) step();
    sig_i = 4'b0100;
    repeat (15) step();
    chk("glitch_sig_o", sig_o, 4'b0100);
    chk("glitch_no_evt", evt_valid, 1'b0);

    // contention from ptr=0
    sig_i = 4'h0;
    apply_reset();
    sig_i = 4'b1010;
    for (int i = 0; i < 40; i++) begin
      if (evt_valid && evt_ready) got_codes.push_back(int'(evt_code));
      step();
    end
    chk("cont_count", got_codes.size(), 2);
    chk("cont_first", (got_codes.size() > 0) ? got_codes[0] : -1, 1);
    chk("cont_second", (got_codes.size() > 1) ? got_codes[1] : -1, 3);

    // overflow: three commits into a 2-deep FIFO with no consumer
    evt_ready = 1'b0;
    sig_i[0] = ~sig_i[0];
    repeat (12) step();
    sig_i[1] = ~sig_i[1];
    repeat (12) step();
    sig_i[2] = ~sig_i[2];
    repeat (12) step();
    chk("ovf_set", ovf, 1'b1);
    chk("ovf_sig_o", sig_o, 4'b1101);
    chk("ovf_head", evt_code, 2'd0);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_cleared", ovf, 1'b0);
    evt_ready = 1'b1;
    repeat (4) step();

    // reset while timing
    sig_i[3] = ~sig_i[3];
    for (int i = 0; i < 10 && !busy; i++) step();
    chk("busy_wait", busy, 1'b1);
    step();
    apply_reset();
    chk("midrst_sig_o", sig_o, 4'h0);
    chk("midrst_evt_valid", evt_valid, 1'b0);

    // randomized phase
    for (int i = 0; i < 2500; i++) begin
      if ((i % 200) < 160 && $urandom_range(0, 5) == 0) begin
        bitn = $urandom_range(0, N - 1);
        sig_i[bitn] = ~sig_i[bitn];
      end
      evt_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      if (i == 1300) apply_reset();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
